// File: rtl/fifo_sync.sv
// Synchronous FIFO (DEPTH = 2**bits words) with registered read port and full/empty/count status.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_SYNC_ERR_EN.
`timescale 1ns/1ps

module addern #(
    parameter int n = 4
) (
    input  logic         carryin,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic [n-1:0] s
);
    logic [n:0] c;

    assign c[0] = carryin;

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_bit
            assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
        end
    endgenerate
endmodule

module fifo_sync #(
    parameter int bits  = 3,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic [bits:0]    count
`ifdef FIFO_SYNC_ERR_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    localparam int DEPTH = 2 ** bits;
    localparam logic [bits:0] ONE = (bits + 1)'(1);

    logic [width-1:0] mem [DEPTH];

    logic [bits:0]    wr_ptr_reg;
    logic [bits:0]    rd_ptr_reg;
    logic [bits:0]    wr_ptr_next;
    logic [bits:0]    rd_ptr_next;
    logic [bits:0]    count_reg;
    logic [bits:0]    count_next;
    logic [width-1:0] rd_data_reg;
    logic             rd_valid_reg;
    logic             wr_acc;
    logic             rd_acc;

    // Pointer increments come from ripple-carry adders (B=0, carry-in=1); wrap is natural.
    addern #(.n(bits + 1)) u_wr_inc (
        .carryin (1'b1),
        .x       (wr_ptr_reg),
        .y       ('0),
        .s       (wr_ptr_next)
    );

    addern #(.n(bits + 1)) u_rd_inc (
        .carryin (1'b1),
        .x       (rd_ptr_reg),
        .y       ('0),
        .s       (rd_ptr_next)
    );

    assign full  = (wr_ptr_reg[bits] != rd_ptr_reg[bits]) &&
                   (wr_ptr_reg[bits-1:0] == rd_ptr_reg[bits-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + ONE;
            2'b01:   count_next = count_reg - ONE;
            default: count_next = count_reg;
        endcase
    end

    // Storage is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_reg[bits-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (rd_acc) begin
                rd_ptr_reg  <= rd_ptr_next;
                rd_data_reg <= mem[rd_ptr_reg[bits-1:0]];
            end
            rd_valid_reg <= rd_acc;
            count_reg    <= count_next;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign count    = count_reg;

`ifdef FIFO_SYNC_ERR_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (bits=3, width=8); checks error flags when FIFO_SYNC_ERR_EN is defined.
`timescale 1ns/1ps

module tb_fifo_sync;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
`ifdef FIFO_SYNC_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    fifo_sync #(.bits(3), .width(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_SYNC_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two clocks with a write request pending
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b0;
        cycle();
        cycle();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
`ifdef FIFO_SYNC_ERR_EN
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`endif
        rst = 1'b0; wr_en = 1'b0;
        cycle();
        check("idle_count", 32'(count), 32'd0);
        $display("step reset: count=%0d empty=%0b", count, empty);

        // Fill
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            cycle();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
            $display("write %0h -> count=%0d full=%0b", wr_data, count, full);
        end
        wr_data = 8'hFF;
        cycle();
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
`ifdef FIFO_SYNC_ERR_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`endif
        $display("write ff while full -> count=%0d", count);
        wr_en = 1'b0;

        // Drain
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            cycle();
            check("drain_valid", 32'(rd_valid), 32'd1);
            check("drain_data", 32'(rd_data), 32'(8'h10 + i));
            check("drain_count", 32'(count), 32'(7 - i));
            $display("read -> data=%0h valid=%0b count=%0d", rd_data, rd_valid, count);
        end
        check("drain_empty", 32'(empty), 32'd1);
        cycle();
        check("udf_valid", 32'(rd_valid), 32'd0);
        check("udf_hold", 32'(rd_data), 32'h17);
        check("udf_count", 32'(count), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        check("udf_flag", 32'(underflow), 32'd1);
`endif
        $display("read while empty -> valid=%0b", rd_valid);
        rd_en = 1'b0;

        // Wrap-around with alternating write/read
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            cycle();
            wr_en = 1'b0;
            check("wrap_count_w", 32'(count), 32'd1);
            rd_en = 1'b1;
            cycle();
            rd_en = 1'b0;
            check("wrap_valid", 32'(rd_valid), 32'd1);
            check("wrap_data", 32'(rd_data), 32'(i));
            check("wrap_count_r", 32'(count), 32'd0);
            $display("wrap pair %0d -> data=%0h", i, rd_data);
        end

        // Simultaneous request while full
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            cycle();
        end
        check("sim_full_pre", 32'(full), 32'd1);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
        cycle();
        check("simf_valid", 32'(rd_valid), 32'd1);
        check("simf_data", 32'(rd_data), 32'h30);
        check("simf_count", 32'(count), 32'd7);
        check("simf_full", 32'(full), 32'd0);
        $display("simultaneous at full -> data=%0h count=%0d", rd_data, count);
        wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cycle();
            check("simf_drain", 32'(rd_data), 32'(8'h30 + i));
            $display("read -> data=%0h count=%0d", rd_data, count);
        end
        check("simf_empty", 32'(empty), 32'd1);

        // Simultaneous request while empty
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
        cycle();
        check("sime_count", 32'(count), 32'd1);
        check("sime_valid", 32'(rd_valid), 32'd0);
        check("sime_empty", 32'(empty), 32'd0);
        $display("simultaneous at empty -> count=%0d valid=%0b", count, rd_valid);
        wr_en = 1'b0;
        cycle();
        check("sime_data", 32'(rd_data), 32'hAA);
        check("sime_valid2", 32'(rd_valid), 32'd1);
        rd_en = 1'b0;
        cycle();

        // Reset in the middle of a read
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            cycle();
        end
        wr_en = 1'b0;
        check("mid_pre_count", 32'(count), 32'd5);
        rd_en = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0; rd_en = 1'b0;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_SYNC_ERR_EN
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_underflow", 32'(underflow), 32'd0);
`endif
        $display("reset mid-read -> count=%0d valid=%0b", count, rd_valid);
        wr_en = 1'b1; wr_data = 8'h55;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("post_rst_data", 32'(rd_data), 32'h55);
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        $display("after reset write/read -> data=%0h", rd_data);
        cycle();
        check("post_rst_valid_drop", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
